// File: rtl/bvurem_slt_witness_checker.sv
// ============================================================================
// bvurem_slt_witness_checker
//
// Checks one candidate witness x against the constraint (x bvurem s) bvslt t.
// A triple (s, t, x) is accepted on an in_valid/in_ready handshake, the
// remainder r = x urem s is produced by a serial restoring divider (one
// quotient bit per cycle), and r is compared against t as two's complement.
// The result is held on out_rem/out_pass with out_valid until consumed.
// Two saturating counters track consumed results and failing results.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   triple on in_s/in_t/in_x is valid
//   in_ready   block can accept a triple (IDLE only)
//   in_s       divisor s, unsigned
//   in_t       bound t, two's complement
//   in_x       candidate witness x, unsigned
//   out_valid  result valid, held until out_ready
//   out_ready  downstream accepts the result
//   out_rem    x urem s (x when s == 0)
//   out_pass   1 when signed(out_rem) < signed(t)
//   busy       high in any state other than IDLE
//   cnt_total  results consumed since reset, saturating
//   cnt_fail   consumed results with out_pass == 0, saturating
// ============================================================================
module bvurem_slt_witness_checker #(
    parameter int W  = 4,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_s,
    input  logic [W-1:0]  in_t,
    input  logic [W-1:0]  in_x,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_rem,
    output logic          out_pass,
    output logic          busy,
    output logic [CW-1:0] cnt_total,
    output logic [CW-1:0] cnt_fail
);

    localparam int KW = $clog2(W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_CMP,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    // Latched operands and divider state
    logic [W-1:0]  s_q;
    logic [W-1:0]  t_q;
    logic [W-1:0]  x_q;
    logic [W-1:0]  rem_q;
    logic [KW-1:0] k_q;

    // Handshake qualifiers, derived from state so they do not depend on the
    // combinational output process
    logic accept;
    logic hs;
    logic last_step;

    // One restoring-division step
    logic [W:0]   p;
    logic [W:0]   diff;
    logic [W-1:0] rem_step;

    assign accept    = in_valid && (state == S_IDLE);
    assign hs        = out_ready && (state == S_DONE);
    assign last_step = (k_q == '0);

    // p = {rem, x[k]}; subtract s when it fits. The difference is always
    // below s, so it fits back into W bits.
    always_comb begin
        p        = {rem_q, x_q[k_q]};
        diff     = p - {1'b0, s_q};
        rem_step = p[W-1:0];
        if (p >= {1'b0, s_q}) begin
            rem_step = diff[W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    // x urem 0 = x: skip the divider entirely
                    state_nxt = (in_s == '0) ? S_CMP : S_DIV;
                end
            end
            S_DIV: begin
                if (last_step) begin
                    state_nxt = S_CMP;
                end
            end
            S_CMP: begin
                state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand capture and divider datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q   <= '0;
            t_q   <= '0;
            x_q   <= '0;
            rem_q <= '0;
            k_q   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        s_q   <= in_s;
                        t_q   <= in_t;
                        x_q   <= in_x;
                        rem_q <= (in_s == '0) ? in_x : '0;
                        k_q   <= KW'(W - 1);
                    end
                end
                S_DIV: begin
                    rem_q <= rem_step;
                    // Wraps after the k=0 step; the value is unused in CMP
                    k_q   <= k_q - KW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Result registers: updated only in CMP so they keep the last result
    // after the handshake
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_rem  <= '0;
            out_pass <= 1'b0;
        end else if (state == S_CMP) begin
            out_rem  <= rem_q;
            out_pass <= ($signed(rem_q) < $signed(t_q));
        end
    end

    // ------------------------------------------------------------------
    // Saturating statistics, advanced only on the output handshake
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_total <= '0;
            cnt_fail  <= '0;
        end else if (hs) begin
            if (cnt_total != '1) begin
                cnt_total <= cnt_total + CW'(1);
            end
            if (!out_pass && (cnt_fail != '1)) begin
                cnt_fail <= cnt_fail + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_bvurem_slt_witness_checker.sv
// ============================================================================
// tb_bvurem_slt_witness_checker
//
// Self-checking bench for bvurem_slt_witness_checker (W=4, CW=16).
// Directed cases cover basic results, latency, back-pressure, ignored input
// while busy and reset mid-division; a full sweep of all (s, t, x) triples
// with random out_ready compares against an arithmetic reference model.
// ============================================================================
module tb_bvurem_slt_witness_checker;

    localparam int W  = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_s;
    logic [W-1:0]  in_t;
    logic [W-1:0]  in_x;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_rem;
    logic          out_pass;
    logic          busy;
    logic [CW-1:0] cnt_total;
    logic [CW-1:0] cnt_fail;

    int n_checks = 0;
    int n_fail   = 0;

    bvurem_slt_witness_checker #(
        .W  (W),
        .CW (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_s      (in_s),
        .in_t      (in_t),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rem   (out_rem),
        .out_pass  (out_pass),
        .busy      (busy),
        .cnt_total (cnt_total),
        .cnt_fail  (cnt_fail)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: plain arithmetic on the spec's rules
    function automatic int ref_rem(input int s, input int x);
        return (s == 0) ? x : (x % s);
    endfunction

    function automatic int sval(input int v);
        return (v >= 2 ** (W - 1)) ? (v - 2 ** W) : v;
    endfunction

    function automatic int ref_pass(input int s, input int t, input int x);
        return (sval(ref_rem(s, x)) < sval(t)) ? 1 : 0;
    endfunction

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a triple, wait for acceptance, then count cycles until out_valid
    task automatic issue(input int s, input int t, input int x, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        check("in_ready_before_issue", in_ready, 1);
        in_s     = W'(s);
        in_t     = W'(t);
        in_x     = W'(x);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin
            step();
            lat++;
        end
        check("out_valid_timeout", out_valid, 1);
    endtask

    // Consume the pending result, optionally with random out_ready stalls
    task automatic consume(input bit rand_ready);
        int guard;
        bit done;
        guard = 0;
        done  = 1'b0;
        while (!done && guard < 100) begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            done      = out_ready && out_valid;
            step();
            guard++;
        end
        out_ready = 1'b0;
        check("handshake_timeout", done, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int exp_total;
        int exp_fail;
        bit seen_valid;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_s      = '0;
        in_t      = '0;
        in_x      = '0;
        step();
        step();

        check("reset_in_ready",  in_ready,  1);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_rem",   out_rem,   0);
        check("reset_out_pass",  out_pass,  0);
        check("reset_busy",      busy,      0);
        check("reset_cnt_total", cnt_total, 0);
        check("reset_cnt_fail",  cnt_fail,  0);
        rst = 1'b0;
        step();

        // 1: s=3 t=2 x=7
        issue(3, 2, 7, lat);
        check("t1_latency",  lat,      W + 2);
        check("t1_rem",      out_rem,  1);
        check("t1_pass",     out_pass, 1);
        check("t1_busy",     busy,     1);
        check("t1_in_ready", in_ready, 0);
        consume(1'b0);
        check("t1_cnt_total",    cnt_total, 1);
        check("t1_cnt_fail",     cnt_fail,  0);
        check("t1_idle_ready",   in_ready,  1);
        check("t1_valid_drop",   out_valid, 0);
        check("t1_rem_held",     out_rem,   1);

        // 2: s=0 -> remainder is x
        issue(0, 0, 9, lat);
        check("t2_latency", lat,      2);
        check("t2_rem",     out_rem,  9);
        check("t2_pass",    out_pass, 1);
        consume(1'b0);
        check("t2_cnt_total", cnt_total, 2);
        check("t2_cnt_fail",  cnt_fail,  0);

        // 3: s=5 t=4 x=14 fails
        issue(5, 4, 14, lat);
        check("t3_latency", lat,      W + 2);
        check("t3_rem",     out_rem,  4);
        check("t3_pass",    out_pass, 0);
        consume(1'b0);
        check("t3_cnt_total", cnt_total, 3);
        check("t3_cnt_fail",  cnt_fail,  1);

        // 4: t = most negative, back-pressure with ignored in_valid pulses
        issue(15, 8, 15, lat);
        check("t4_latency", lat, W + 2);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_s     = 4'd1;
            in_t     = 4'd7;
            in_x     = 4'd2;
            in_valid = (i % 2 == 0);
            step();
            check("t4_hold_valid",     out_valid, 1);
            check("t4_hold_rem",       out_rem,   0);
            check("t4_hold_pass",      out_pass,  0);
            check("t4_hold_cnt_total", cnt_total, 3);
            check("t4_hold_cnt_fail",  cnt_fail,  1);
            check("t4_hold_in_ready",  in_ready,  0);
        end
        in_valid = 1'b0;
        consume(1'b0);
        check("t4_cnt_total", cnt_total, 4);
        check("t4_cnt_fail",  cnt_fail,  2);
        seen_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid || busy) seen_valid = 1'b1;
        end
        check("t4_no_stray_capture", seen_valid, 0);

        // 5: reset during the 2nd DIV cycle
        in_s     = 4'd3;
        in_t     = 4'd0;
        in_x     = 4'd11;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("t5_div_busy", busy, 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_in_ready",  in_ready,  1);
        check("t5_out_valid", out_valid, 0);
        check("t5_busy",      busy,      0);
        check("t5_cnt_total", cnt_total, 0);
        check("t5_cnt_fail",  cnt_fail,  0);
        check("t5_out_rem",   out_rem,   0);
        seen_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid) seen_valid = 1'b1;
        end
        check("t5_aborted_never_output", seen_valid, 0);

        // 6: exhaustive sweep with random back-pressure
        exp_total = 0;
        exp_fail  = 0;
        for (int s = 0; s < 2 ** W; s++) begin
            for (int t = 0; t < 2 ** W; t++) begin
                for (int x = 0; x < 2 ** W; x++) begin
                    issue(s, t, x, lat);
                    check("sweep_latency", lat, (s == 0) ? 2 : W + 2);
                    check("sweep_rem",  out_rem,  ref_rem(s, x));
                    check("sweep_pass", out_pass, ref_pass(s, t, x));
                    exp_total++;
                    if (ref_pass(s, t, x) == 0) exp_fail++;
                    consume(1'b1);
                end
            end
        end
        check("sweep_cnt_total", cnt_total, exp_total);
        check("sweep_cnt_fail",  cnt_fail,  exp_fail);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
